vv_alu_config_ctrl: RTL

//  Firmware loader/sequencer for vectorVectorALU. Consumes the shared byte-wide config bus (configId/configData)
//  and quiesces the ALU by gating its tracing input. Waits out the ALU pipeline, then writes the six per-chain

---
 rtl/vv_cfg_pkg.sv | 23 ++
 rtl/vv_alu_config_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vv_cfg_pkg.sv
// Shared types for the vectorVectorALU firmware loader: sequencer states,
// firmware table selectors and the config-bus header code that starts a load.
package vv_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } cfg_state_e;

   typedef enum logic [2:0] {
      FW_OP         = 3'd0,
      FW_ADDR_RD    = 3'd1,
      FW_COND       = 3'd2,
      FW_CACHE      = 3'd3,
      FW_CACHE_ADDR = 3'd4,
      FW_CACHE_COND = 3'd5
   } fw_field_e;

   localparam logic [7:0] CFG_HDR_LOAD = 8'hA5;

endpackage

// File: rtl/vv_alu_config_ctrl.sv
// Firmware loader/sequencer for one vectorVectorALU: gates tracing, drains the
// ALU pipeline, then streams the per-chain firmware tables out of the config bus.
module vv_alu_config_ctrl
   import vv_cfg_pkg::*;
#(
   parameter int MAX_CHAINS         = 4,
   parameter int PERSONAL_CONFIG_ID = 0,
   parameter int DRAIN_CYCLES       = 2,
   parameter int NUM_FIELDS         = 6
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          tracing_in,
   input  logic                          cfg_valid,
   input  logic [7:0]                    cfg_id,
   input  logic [7:0]                    cfg_data,
   output logic                          cfg_ready,
   output logic                          tracing,
   output logic                          fw_we,
   output logic [2:0]                    fw_field,
   output logic [$clog2(MAX_CHAINS)-1:0] fw_chain,
   output logic [7:0]                    fw_data,
   output logic                          busy,
   output logic                          err
);

   localparam int CW = $clog2(MAX_CHAINS);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   cfg_state_e    state_q, state_d;
   logic [DW-1:0] drain_q, drain_d;
   fw_field_e     field_q, field_d;
   logic [CW-1:0] chain_q, chain_d;
   logic          we_q, we_d;
   logic [2:0]    wfield_q, wfield_d;
   logic [CW-1:0] wchain_q, wchain_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          err_q, err_d;

   logic accept, match, last_beat;

   assign cfg_ready = (state_q == IDLE) || (state_q == LOAD);
   assign tracing   = tracing_in && (state_q == IDLE);
   assign busy      = (state_q != IDLE);

   assign accept    = cfg_valid && cfg_ready;
   assign match     = (cfg_id == 8'(PERSONAL_CONFIG_ID));
   assign last_beat = (field_q == 3'(NUM_FIELDS - 1)) && (chain_q == CW'(MAX_CHAINS - 1));

   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      field_d  = field_q;
      chain_d  = chain_q;
      we_d     = 1'b0;
      wfield_d = wfield_q;
      wchain_d = wchain_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            // Foreign-id beats are swallowed here so the shared bus never stalls.
            if (accept && match) begin
               if (cfg_data == CFG_HDR_LOAD) begin
                  err_d   = 1'b0;
                  drain_d = DW'(DRAIN_CYCLES - 1);
                  state_d = DRAIN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (drain_q == '0) begin
               field_d = FW_OP;
               chain_d = '0;
               state_d = LOAD;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         LOAD: begin
            if (accept) begin
               if (match) begin
                  we_d     = 1'b1;
                  wfield_d = field_q;
                  wchain_d = chain_q;
                  wdata_d  = cfg_data;
                  if (last_beat) begin
                     state_d = DONE;
                  end else if (chain_q == CW'(MAX_CHAINS - 1)) begin
                     chain_d = '0;
                     field_d = fw_field_e'(field_q + 3'd1);
                  end else begin
                     chain_d = chain_q + 1'b1;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Firmware contents live in the ALU; only sequencing state is cleared here.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         drain_q  <= '0;
         field_q  <= FW_OP;
         chain_q  <= '0;
         we_q     <= 1'b0;
         wfield_q <= '0;
         wchain_q <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         drain_q  <= drain_d;
         field_q  <= field_d;
         chain_q  <= chain_d;
         we_q     <= we_d;
         wfield_q <= wfield_d;
         wchain_q <= wchain_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
      end
   end

   assign fw_we    = we_q;
   assign fw_field = wfield_q;
   assign fw_chain = wchain_q;
   assign fw_data  = wdata_q;
   assign err      = err_q;

endmodule
